// File: rtl/port_uart_tx_if.sv
// Port-side bus between byter's decoded OUT/IN port logic and the UART transmit stage.
// The master drives the write strobe and data; the slave returns the pollable status.
interface port_uart_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic [7:0] status;
  logic       busy;
  logic       full;
  logic       empty;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  status, busy, full, empty
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output status, busy, full, empty
  );
endinterface

// File: rtl/port_uart_tx.sv
// Byte FIFO feeding an 8N1 serial transmitter.
// Frames run back to back whenever the FIFO still holds data at the end of a stop bit.
module port_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  port_uart_tx_if.slave bus,
  output logic          tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    shift;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;

  logic full;
  logic empty;
  logic baud_tc;
  logic pop;
  logic push;
  logic drop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign baud_tc = (baud == BAUD_LAST);
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && baud_tc));
  // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
  assign push    = bus.wr_en && (!full || pop);
  assign drop    = bus.wr_en && full && !pop;

  assign bus.full   = full;
  assign bus.empty  = empty;
  assign bus.busy   = (state != IDLE) || !empty;
  assign bus.status = {5'b0, overflow, full, bus.busy};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      // A new overflow takes priority over a clear in the same cycle.
      if (drop) begin
        overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      baud    <= '0;
      bit_idx <= '0;
    end else begin
      if (state != IDLE) begin
        baud <= baud_tc ? '0 : baud + BW'(1);
      end
      case (state)
        IDLE: begin
          baud    <= '0;
          bit_idx <= '0;
          tx      <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_tc) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (baud_tc) begin
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
              tx      <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end
        end
        STOP: begin
          if (baud_tc) begin
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule
